// File: rtl/gpp_seq.sv
// gpp_seq: packet-level sequencer for the generic packet parser.
// Tracks SOP/EOP framing on a 32-bit word stream, tags header words with
// their parser stage, and pulses header/packet completion and framing or
// length errors one cycle after the triggering word is accepted.
// Optional statistics counters are enabled by defining GPP_SEQ_STATS_EN.
module gpp_seq #(
    parameter int NUM_STAGES    = 3,
    parameter int STG_W         = 4,
    parameter int MAX_PKT_WORDS = 1024,
    parameter int CNT_W         = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din_v,
    input  logic             din_sop,
    input  logic             din_eop,
    input  logic             stall,
    output logic             din_rdy,
    output logic [STG_W-1:0] pp_stage,
    output logic             pp_stage_v,
    output logic             hdr_done,
    output logic             pkt_done,
    output logic [CNT_W-1:0] pkt_len,
    output logic             err_short,
    output logic             err_long,
    output logic             err_proto,
`ifdef GPP_SEQ_STATS_EN
    input  logic             stat_clr,
    output logic [15:0]      stat_pkts,
    output logic [15:0]      stat_errs,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        BODY  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [STG_W-1:0] LAST_STG = STG_W'(NUM_STAGES - 1);
    localparam logic [CNT_W-1:0] MAX_W    = CNT_W'(MAX_PKT_WORDS);
    localparam logic [CNT_W-1:0] ONE_W    = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [STG_W-1:0] stage_reg, stage_next;
    logic [CNT_W-1:0] wcnt_reg, wcnt_next;
    logic [CNT_W-1:0] wcnt_inc;
    logic [CNT_W-1:0] pkt_len_reg, pkt_len_next;
    logic             hdr_done_reg, hdr_done_next;
    logic             pkt_done_reg, pkt_done_next;
    logic             err_short_reg, err_short_next;
    logic             err_long_reg, err_long_next;
    logic             err_proto_reg, err_proto_next;
    logic             acc;

    // Handshake and stage tagging; a sop in any state is stage 0 of a new packet.
    always_comb begin
        din_rdy    = ~stall;
        acc        = din_v & ~stall;
        pp_stage_v = acc & (din_sop | (state_reg == HDR));
        pp_stage   = (din_sop || state_reg != HDR) ? '0 : stage_reg;
        busy       = (state_reg != IDLE);
    end

    // Next-state and pulse generation; nothing moves unless a word is accepted.
    always_comb begin
        state_next     = state_reg;
        stage_next     = stage_reg;
        wcnt_next      = wcnt_reg;
        pkt_len_next   = pkt_len_reg;
        hdr_done_next  = 1'b0;
        pkt_done_next  = 1'b0;
        err_short_next = 1'b0;
        err_long_next  = 1'b0;
        err_proto_next = 1'b0;
        wcnt_inc       = wcnt_reg + ONE_W;
        if (acc) begin
            if (din_sop) begin
                // New packet start; outside IDLE it aborts the current one.
                err_proto_next = (state_reg != IDLE);
                wcnt_next      = ONE_W;
                stage_next     = '0;
                if (NUM_STAGES == 1) begin
                    hdr_done_next = 1'b1;
                    if (din_eop) begin
                        pkt_done_next = 1'b1;
                        pkt_len_next  = ONE_W;
                        state_next    = IDLE;
                    end else if (MAX_W == ONE_W) begin
                        err_long_next = 1'b1;
                        state_next    = DRAIN;
                    end else begin
                        state_next = BODY;
                    end
                end else if (din_eop) begin
                    err_short_next = 1'b1;
                    state_next     = IDLE;
                end else begin
                    stage_next = STG_W'(1);
                    state_next = HDR;
                end
            end else begin
                case (state_reg)
                    IDLE: begin
                        err_proto_next = 1'b1;
                    end
                    HDR: begin
                        wcnt_next = wcnt_inc;
                        if (stage_reg == LAST_STG) begin
                            hdr_done_next = 1'b1;
                            stage_next    = '0;
                            if (din_eop) begin
                                pkt_done_next = 1'b1;
                                pkt_len_next  = wcnt_inc;
                                state_next    = IDLE;
                            end else if (wcnt_inc == MAX_W) begin
                                // Header alone fills the length budget.
                                err_long_next = 1'b1;
                                state_next    = DRAIN;
                            end else begin
                                state_next = BODY;
                            end
                        end else if (din_eop) begin
                            err_short_next = 1'b1;
                            stage_next     = '0;
                            state_next     = IDLE;
                        end else begin
                            stage_next = stage_reg + STG_W'(1);
                        end
                    end
                    BODY: begin
                        if (din_eop) begin
                            pkt_done_next = 1'b1;
                            pkt_len_next  = wcnt_inc;
                            state_next    = IDLE;
                        end else if (wcnt_inc == MAX_W) begin
                            err_long_next = 1'b1;
                            state_next    = DRAIN;
                        end else begin
                            wcnt_next = wcnt_inc;
                        end
                    end
                    DRAIN: begin
                        if (din_eop) begin
                            state_next = IDLE;
                        end
                    end
                    default: begin
                        state_next = IDLE;
                    end
                endcase
            end
        end
    end

    // State, counters and registered pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            stage_reg     <= '0;
            wcnt_reg      <= '0;
            pkt_len_reg   <= '0;
            hdr_done_reg  <= 1'b0;
            pkt_done_reg  <= 1'b0;
            err_short_reg <= 1'b0;
            err_long_reg  <= 1'b0;
            err_proto_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            stage_reg     <= stage_next;
            wcnt_reg      <= wcnt_next;
            pkt_len_reg   <= pkt_len_next;
            hdr_done_reg  <= hdr_done_next;
            pkt_done_reg  <= pkt_done_next;
            err_short_reg <= err_short_next;
            err_long_reg  <= err_long_next;
            err_proto_reg <= err_proto_next;
        end
    end

    assign hdr_done  = hdr_done_reg;
    assign pkt_done  = pkt_done_reg;
    assign pkt_len   = pkt_len_reg;
    assign err_short = err_short_reg;
    assign err_long  = err_long_reg;
    assign err_proto = err_proto_reg;

`ifdef GPP_SEQ_STATS_EN
    logic [15:0] stat_pkts_reg;
    logic [15:0] stat_errs_reg;
    logic        any_err_next;

    assign any_err_next = err_short_next | err_long_next | err_proto_next;

    // Saturating event counters, updated on the same edge as the pulses; clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_pkts_reg <= '0;
            stat_errs_reg <= '0;
        end else if (stat_clr) begin
            stat_pkts_reg <= '0;
            stat_errs_reg <= '0;
        end else begin
            if (pkt_done_next && stat_pkts_reg != 16'hFFFF) begin
                stat_pkts_reg <= stat_pkts_reg + 16'd1;
            end
            if (any_err_next && stat_errs_reg != 16'hFFFF) begin
                stat_errs_reg <= stat_errs_reg + 16'd1;
            end
        end
    end

    assign stat_pkts = stat_pkts_reg;
    assign stat_errs = stat_errs_reg;
`endif

endmodule
